// File: rtl/gvt_reducer_if.sv
// Tile-to-reducer bundle: per-tile LVT offers with ready, host enable, and the GVT broadcast.
// master = tiles/host side, slave = the reducer.
interface gvt_reducer_if #(
    parameter int unsigned N_TILES = 1,
    parameter int unsigned VT_W    = 64
);
    logic                    gvt_en;
    logic [N_TILES-1:0]      lvt_valid;
    logic [N_TILES-1:0]      lvt_ready;
    logic [N_TILES*VT_W-1:0] lvt;
    logic [VT_W-1:0]         gvt;
    logic                    gvt_valid;
    logic                    gvt_regress;
    logic [15:0]             round_count;

    modport master (
        output gvt_en, lvt_valid, lvt,
        input  lvt_ready, gvt, gvt_valid, gvt_regress, round_count
    );

    modport slave (
        input  gvt_en, lvt_valid, lvt,
        output lvt_ready, gvt, gvt_valid, gvt_regress, round_count
    );
endinterface

// File: rtl/gvt_reducer.sv
// Periodic GVT reduction: collect one LVT per tile, fold them to a minimum one tile per cycle,
// then publish a monotonic GVT and flag any round whose minimum falls below it.
module gvt_reducer #(
    parameter int unsigned N_TILES        = 1,
    parameter int unsigned TS_WIDTH       = 32,
    parameter int unsigned TB_WIDTH       = 32,
    parameter int unsigned LOG_GVT_PERIOD = 5,
    parameter int unsigned VT_W           = TS_WIDTH + TB_WIDTH
) (
    input logic          clk,
    input logic          rstn,
    gvt_reducer_if.slave gvt_if
);
    localparam int unsigned RW = (N_TILES > 1) ? $clog2(N_TILES) : 1;
    localparam logic [LOG_GVT_PERIOD-1:0] PcntLast = '1;
    localparam logic [RW-1:0] RLast = RW'(N_TILES - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StReduce, StPublish} state_e;

    state_e                    state_q, state_d;
    logic [LOG_GVT_PERIOD-1:0] pcnt_q, pcnt_d;
    logic [N_TILES-1:0]        got_q, got_d;
    logic [RW-1:0]             r_q, r_d;
    logic [VT_W-1:0]           snap_q [N_TILES];
    logic [VT_W-1:0]           snap_d [N_TILES];
    logic [VT_W-1:0]           acc_q, acc_d;
    logic [VT_W-1:0]           gvt_q, gvt_d;
    logic                      gvt_valid_q, gvt_valid_d;
    logic                      regress_q, regress_d;
    logic [15:0]               round_count_q, round_count_d;
    logic [N_TILES-1:0]        lvt_ready;
    logic [N_TILES-1:0]        accept;

    always_comb begin
        lvt_ready = '0;
        if (state_q == StCollect) begin
            lvt_ready = ~got_q;
        end
    end

    assign accept = gvt_if.lvt_valid & lvt_ready;

    always_comb begin
        state_d       = state_q;
        pcnt_d        = pcnt_q;
        got_d         = got_q;
        r_d           = r_q;
        snap_d        = snap_q;
        acc_d         = acc_q;
        gvt_d         = gvt_q;
        gvt_valid_d   = 1'b0;
        regress_d     = regress_q;
        round_count_d = round_count_q;

        unique case (state_q)
            StIdle: begin
                // Counter wraps naturally at terminal count whether or not a round starts.
                pcnt_d = pcnt_q + 1'b1;
                if (pcnt_q == PcntLast && gvt_if.gvt_en) begin
                    state_d = StCollect;
                    got_d   = '0;
                end
            end
            StCollect: begin
                for (int i = 0; i < N_TILES; i++) begin
                    if (accept[i]) begin
                        snap_d[i] = gvt_if.lvt[i*VT_W +: VT_W];
                    end
                end
                got_d = got_q | accept;
                if (&got_d) begin
                    state_d = StReduce;
                    r_d     = '0;
                end
            end
            StReduce: begin
                if (r_q == '0) begin
                    acc_d = snap_q[0];
                end else if (snap_q[r_q] < acc_q) begin
                    acc_d = snap_q[r_q];
                end
                if (r_q == RLast) begin
                    state_d = StPublish;
                end else begin
                    r_d = r_q + 1'b1;
                end
            end
            StPublish: begin
                if (acc_q >= gvt_q) begin
                    gvt_d = acc_q;
                end else begin
                    regress_d = 1'b1;
                end
                gvt_valid_d   = 1'b1;
                round_count_d = round_count_q + 16'd1;
                state_d       = StIdle;
                pcnt_d        = '0;
                got_d         = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= StIdle;
            pcnt_q        <= '0;
            got_q         <= '0;
            r_q           <= '0;
            for (int i = 0; i < N_TILES; i++) begin
                snap_q[i] <= '0;
            end
            acc_q         <= '0;
            gvt_q         <= '0;
            gvt_valid_q   <= 1'b0;
            regress_q     <= 1'b0;
            round_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pcnt_q        <= pcnt_d;
            got_q         <= got_d;
            r_q           <= r_d;
            snap_q        <= snap_d;
            acc_q         <= acc_d;
            gvt_q         <= gvt_d;
            gvt_valid_q   <= gvt_valid_d;
            regress_q     <= regress_d;
            round_count_q <= round_count_d;
        end
    end

    assign gvt_if.lvt_ready   = lvt_ready;
    assign gvt_if.gvt         = gvt_q;
    assign gvt_if.gvt_valid   = gvt_valid_q;
    assign gvt_if.gvt_regress = regress_q;
    assign gvt_if.round_count = round_count_q;
endmodule

// File: doc/gvt_reducer.md
# gvt_reducer

Periodic global-virtual-time (GVT) reduction stage for the Swarm tile array. It sits between the per-tile commit queues, which report their local minimum virtual time (LVT), and the GVT broadcast consumed by every commit queue for in-order commit. Every 2^LOG_GVT_PERIOD cycles it collects one LVT per tile and reduces them sequentially to a minimum. It then publishes a monotonic GVT and flags any regression.

## Interface
Parameters:
- N_TILES, 1: number of reporting tiles (1..64).
- TS_WIDTH, 32: timestamp width.
- TB_WIDTH, 32: tiebreaker width.
- LOG_GVT_PERIOD, 5: log2 of cycles between reduction rounds.
- VT_W, TS_WIDTH+TB_WIDTH: derived VT width, {ts, tb}, compared unsigned.

Ports:
- clk  in  1  single clock domain.
- rstn  in  1  asynchronous active-low reset.
- gvt_en  in  1  host enable; gates only the start of a round.
- lvt_valid  in  N_TILES  tile i offers its LVT.
- lvt_ready  out  N_TILES  reducer accepts tile i's LVT.
- lvt  in  N_TILES*VT_W  tile i LVT at bits [i*VT_W +: VT_W].
- gvt  out  VT_W  current published GVT (registered).
- gvt_valid  out  1  one-cycle pulse when gvt is (re)published.
- gvt_regress  out  1  sticky error: a round's minimum was below the current gvt.
- round_count  out  16  completed rounds, wraps at 2^16.

## Operation
- State machine: IDLE, COLLECT, REDUCE, PUBLISH.
- IDLE:
  - Period counter pcnt counts 0..2^LOG_GVT_PERIOD-1 and wraps.
  - At terminal count with gvt_en=1, go to COLLECT next cycle. Clear the got[] mask and pcnt.
  - At terminal count with gvt_en=0, wrap and stay in IDLE.
- COLLECT:
  - lvt_ready[i] = ~got[i]. On lvt_valid[i]&lvt_ready[i], capture lvt slice i into snap[i] and set got[i].
  - Any number of tiles may be accepted in the same cycle.
  - When got is all ones after the cycle's updates, go to REDUCE next cycle.
  - No timeout: a silent tile stalls the round indefinitely.
  - Deasserting gvt_en mid-round does not abort the round.
- REDUCE:
  - Index r runs 0..N_TILES-1, one tile per cycle.
  - acc <= (r==0) ? snap[0] : min(acc, snap[r]).
  - After r = N_TILES-1, go to PUBLISH.
- PUBLISH (one cycle):
  - If acc >= gvt: gvt <= acc.
  - Else: gvt holds and gvt_regress <= 1.
  - gvt_valid is 1 in the cycle following PUBLISH in both cases. round_count increments.
  - Return to IDLE with pcnt=0.
- An all-ones VT means the tile is idle. It is reduced like any other value, so all tiles idle publishes gvt = all ones.
- Reset mid-round: everything returns to reset values immediately. Partial snapshots are discarded.

## Timing
Reset values:
- gvt=0, gvt_valid=0, lvt_ready=0, gvt_regress=0, round_count=0.
- State=IDLE, pcnt=0, got=0.

Cycle counts:
- The first COLLECT cycle is the 2^LOG_GVT_PERIOD-th cycle after reset release, if gvt_en=1 throughout.
- lvt_ready is combinational from state and got; it is 0 outside COLLECT.
- Last accept at cycle t: REDUCE occupies t+1..t+N_TILES and PUBLISH is t+N_TILES+1.
- gvt and gvt_valid become visible at t+N_TILES+2.
- Minimum round length is 2^LOG_GVT_PERIOD + 1 + N_TILES + 1 cycles between consecutive gvt_valid pulses.
- gvt only changes on gvt_valid cycles.

## Test plan
Shared setup: N_TILES=4, LOG_GVT_PERIOD=2, TS/TB=32/32.

- Basic round:
  - Stimulus: all tiles valid at first COLLECT with LVTs {ts,tb} = {10,3},{7,9},{7,2},{20,0}.
  - Required: gvt={7,2}, gvt_valid pulse exactly 6 cycles after COLLECT entry, round_count=1.
- Staggered reporting:
  - Stimulus: tiles report in cycles 0, 3, 3, 8 of COLLECT.
  - Required: lvt_ready[i] drops the cycle after each accept. No REDUCE before cycle 9. Duplicate valids from already-reported tiles are ignored.
- Regression:
  - Stimulus: round 1 min {50,0}, round 2 min {40,0}.
  - Required: gvt stays {50,0}, gvt_valid still pulses, gvt_regress=1 and sticky through round 3.
- Enable gating:
  - Stimulus: gvt_en=0 for 20 cycles.
  - Required: no COLLECT, lvt_ready=0, no gvt_valid.
  - Stimulus: drop gvt_en mid-COLLECT.
  - Required: the round completes.
- All idle:
  - Stimulus: all LVTs = 64'hFFFF_FFFF_FFFF_FFFF.
  - Required: gvt = all ones, no regress.
- Reset mid-REDUCE:
  - Stimulus: assert rstn=0 asynchronously during REDUCE.
  - Required: immediately gvt=0, gvt_valid=0, lvt_ready=0, round_count=0. After release, the next COLLECT starts 4 cycles later.
